// File: rtl/video_reverb.sv
// Video reverb stage: mixes each active pixel with a decaying, horizontally
// offset echo of the previous line's mix, kept in a one-line buffer.
module video_reverb #(
    parameter  int unsigned H_ACTIVE = 1280,
    parameter  int unsigned V_ACTIVE = 720,
    localparam int unsigned HW       = $clog2(H_ACTIVE),
    localparam int unsigned VW       = $clog2(V_ACTIVE)
) (
    input  logic          clk_pixel,
    input  logic          rst_n,
    input  logic [HW-1:0] h_count_in,
    input  logic [VW-1:0] v_count_in,
    input  logic          active_draw_in,
    input  logic [23:0]   pixel_in,
    input  logic [9:0]    wet,
    input  logic [9:0]    size,
    input  logic [9:0]    feedback,
    output logic [HW-1:0] h_count_out,
    output logic [VW-1:0] v_count_out,
    output logic          active_draw_out,
    output logic [23:0]   pixel_out
);
    localparam int unsigned LATENCY = 4;
    localparam int unsigned PW      = 24;
    localparam int unsigned AW      = HW + 1;
    localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);

    // echo gain applied to one channel, saturated back to 8 bits
    function automatic logic [7:0] mix8(input logic [7:0] x, input logic [7:0] e,
                                        input logic [9:0] g);
        logic [17:0] prod;
        logic [8:0]  sum;
        prod = 18'(e) * 18'(g);
        sum  = 9'(x) + 9'(prod[17:10]);
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    function automatic logic [7:0] blend8(input logic [7:0] dry, input logic [7:0] wm,
                                          input logic [9:0] w);
        logic [17:0] acc;
        acc = 18'(dry) * 18'(11'd1024 - 11'(w)) + 18'(wm) * 18'(w);
        return acc[17:10];
    endfunction

    logic [9:0]    wet_q, fb_q;
    logic [5:0]    off_q;
    logic          unused_size_c;
    logic [HW-1:0] h_q   [LATENCY];
    logic [VW-1:0] v_q   [LATENCY];
    logic          act_q [LATENCY];
    logic [HW-1:0] rd_addr_q;
    logic [PW-1:0] rd_data_q;
    logic [PW-1:0] pix1_q, pix2_q, pix3_q, mix_q, pixel_q;
    logic          en1_q, en2_q;
    logic          act_prev_q, run_ok_q, end_ok_q, hist_valid_q;
    logic [AW-1:0] rd_sum_c;
    logic [HW-1:0] rd_addr_c;
    logic          echo_en_c, wr_en_c;
    logic [PW-1:0] mix_d, pixel_d;
    logic [PW-1:0] mem [H_ACTIVE];

    assign unused_size_c = ^size[3:0];

    // frame-start parameter latch
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            wet_q <= '0;
            fb_q  <= '0;
            off_q <= '0;
        end else if (h_count_in == '0 && v_count_in == '0) begin
            wet_q <= wet;
            fb_q  <= feedback;
            off_q <= size[9:4];
        end
    end

    assign rd_sum_c  = AW'(h_count_in) + AW'(off_q);
    assign rd_addr_c = (rd_sum_c >= AW'(H_ACTIVE)) ? H_LAST : rd_sum_c[HW-1:0];
    assign echo_en_c = hist_valid_q && (v_count_in != '0);

    // hist_valid only after a line has been written end to end from h=0
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            act_prev_q   <= 1'b0;
            run_ok_q     <= 1'b0;
            end_ok_q     <= 1'b0;
            hist_valid_q <= 1'b0;
        end else begin
            act_prev_q <= active_draw_in;
            if (active_draw_in) begin
                if (!act_prev_q) run_ok_q <= (h_count_in == '0);
                if (h_count_in == H_LAST && (act_prev_q ? run_ok_q : (h_count_in == '0)))
                    end_ok_q <= 1'b1;
                if (v_count_in == '0) hist_valid_q <= 1'b0;
            end else if (act_prev_q) begin
                if (end_ok_q) hist_valid_q <= 1'b1;
                end_ok_q <= 1'b0;
            end
        end
    end

    always_comb begin
        mix_d = '0;
        for (int c = 0; c < 3; c++)
            mix_d[c*8 +: 8] = mix8(pix2_q[c*8 +: 8], en2_q ? rd_data_q[c*8 +: 8] : 8'd0, fb_q);
    end

    always_comb begin
        pixel_d = '0;
        if (act_q[2])
            for (int c = 0; c < 3; c++)
                pixel_d[c*8 +: 8] = blend8(pix3_q[c*8 +: 8], mix_q[c*8 +: 8], wet_q);
    end

    assign wr_en_c = act_q[2] && (h_q[2] <= H_LAST);

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            h_q       <= '{default: '0};
            v_q       <= '{default: '0};
            act_q     <= '{default: 1'b0};
            rd_addr_q <= '0;
            pix1_q    <= '0;
            pix2_q    <= '0;
            pix3_q    <= '0;
            en1_q     <= 1'b0;
            en2_q     <= 1'b0;
            mix_q     <= '0;
            pixel_q   <= '0;
        end else begin
            h_q[0]   <= h_count_in;
            v_q[0]   <= v_count_in;
            act_q[0] <= active_draw_in;
            for (int i = 1; i < LATENCY; i++) begin
                h_q[i]   <= h_q[i-1];
                v_q[i]   <= v_q[i-1];
                act_q[i] <= act_q[i-1];
            end
            rd_addr_q <= rd_addr_c;
            pix1_q    <= pixel_in;
            en1_q     <= echo_en_c;
            pix2_q    <= pix1_q;
            en2_q     <= en1_q;
            pix3_q    <= pix2_q;
            mix_q     <= mix_d;
            pixel_q   <= pixel_d;
        end
    end

    // line buffer; reads run ahead of writes so no bypass is needed
    always_ff @(posedge clk_pixel) begin
        rd_data_q <= mem[rd_addr_q];
        if (wr_en_c) mem[h_q[2]] <= mix_q;
    end

    assign h_count_out     = h_q[LATENCY-1];
    assign v_count_out     = v_q[LATENCY-1];
    assign active_draw_out = act_q[LATENCY-1];
    assign pixel_out       = pixel_q;
endmodule
